// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the instruction-fetch sequencer.
//   - SEL_PC_* : pc_mux select encodings. They mirror the pc_mux header so that
//                fetch_ctrl and pc_mux agree on the select bus.
//   - fc_state_e : fetch FSM states (FC_REQ / FC_WAIT / FC_DRAIN, 2 bits).
//   - is_misaligned() : word-alignment test used by the optional fault logic.
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

    localparam int SEL_PC_WIDTH = 2;

    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_ADD4 = 2'd0;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JAL  = 2'd1;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JALR = 2'd2;

    localparam int FC_STATE_W = 2;

    typedef enum logic [FC_STATE_W-1:0] {
        FC_REQ   = 2'd0,  // request may be presented, address = pc_q
        FC_WAIT  = 2'd1,  // one request outstanding, response wanted
        FC_DRAIN = 2'd2   // one request outstanding, response to be dropped
    } fc_state_e;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// One-entry pc/instruction holding register between instruction memory and
// decode. Pop (valid_o & ready_i) and push may happen in the same cycle; a
// flush empties the entry and wins over everything else. Contents stay stable
// while valid_o is high and ready_i is low.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   flush_i         : drop any held entry
//   push_i          : load {push_pc_i, push_inst_i}
//   valid_o, pc_o, inst_o : held entry towards decode
//   ready_i         : decode accepts the held entry
//   full_blocked_o  : entry held and not being taken this cycle
// -----------------------------------------------------------------------------
module fetch_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        push_i,
    input  logic [31:0] push_pc_i,
    input  logic [31:0] push_inst_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    input  logic        ready_i,
    output logic        full_blocked_o
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (push_i) begin
            valid_d = 1'b1;
            pc_d    = push_pc_i;
            inst_d  = push_inst_i;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= 32'd0;
            inst_q  <= 32'd0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign valid_o        = valid_q;
    assign pc_o           = pc_q;
    assign inst_o         = inst_q;
    assign full_blocked_o = valid_q & ~ready_i;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer. Owns the fetch PC (pc_q), drives the external
// pc_mux every cycle, keeps at most one instruction-memory request in flight
// and hands fetched words to decode through a one-entry buffer (fetch_buf).
// Execute-stage redirects have priority over hazard stalls, which have
// priority over normal sequential advance.
//
// Build option
//   FETCH_CTRL_MISALIGN_EN : adds output fetch_fault. A redirect to a target
//   with addr[1:0] != 0 still loads pc_q but sets a sticky fault that stops
//   all further requests until rst.
//
// Ports
//   clk, rst                     : clock, synchronous active-high reset
//   mux_pc/rs1/imm/pc_sel/taken/stall : operands and controls to pc_mux
//   mux_next_pc                  : pc_mux result, next value of pc_q
//   imem_req_valid/addr/ready    : request channel to instruction memory
//   imem_rsp_valid/data          : response channel (one per accepted request)
//   if_valid/pc/inst, if_ready   : instruction handoff to decode
//   ex_redirect/pc_sel/taken/pc/rs1/imm : redirect from execute
//   hazard_stall                 : freeze fetch
//   fetch_fault                  : sticky misaligned-target flag (option only)
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [31:0]             mux_pc,
    output logic [31:0]             mux_rs1,
    output logic [31:0]             mux_imm,
    output logic [SEL_PC_WIDTH-1:0] mux_pc_sel,
    output logic                    mux_taken,
    output logic                    mux_stall,
    input  logic [31:0]             mux_next_pc,
    output logic                    imem_req_valid,
    output logic [31:0]             imem_req_addr,
    input  logic                    imem_req_ready,
    input  logic                    imem_rsp_valid,
    input  logic [31:0]             imem_rsp_data,
    output logic                    if_valid,
    output logic [31:0]             if_pc,
    output logic [31:0]             if_inst,
    input  logic                    if_ready,
    input  logic                    ex_redirect,
    input  logic [SEL_PC_WIDTH-1:0] ex_pc_sel,
    input  logic                    ex_taken,
    input  logic [31:0]             ex_pc,
    input  logic [31:0]             ex_rs1,
    input  logic [31:0]             ex_imm,
`ifdef FETCH_CTRL_MISALIGN_EN
    output logic                    fetch_fault,
`endif
    input  logic                    hazard_stall
);

    fc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;   // address of the request in flight

    logic        buf_blocked;
    logic        buf_push;
    logic        fault_halt;
    logic        req_ok;
    logic        advance;

    // A redirect in REQ withholds the request: pc_q is about to change, so the
    // current address is on the wrong path.
    assign req_ok = (state_q == FC_REQ) & ~ex_redirect & ~hazard_stall
                  & ~buf_blocked & ~fault_halt;
    assign advance        = req_ok & imem_req_ready;
    assign imem_req_valid = req_ok;
    assign imem_req_addr  = pc_q;

    // pc_mux drive
    always_comb begin
        mux_pc     = pc_q;
        mux_rs1    = 32'd0;
        mux_imm    = 32'd0;
        mux_pc_sel = SEL_PC_ADD4;
        mux_taken  = 1'b0;
        mux_stall  = ~advance;
        if (ex_redirect) begin
            mux_pc     = ex_pc;
            mux_rs1    = ex_rs1;
            mux_imm    = ex_imm;
            mux_pc_sel = ex_pc_sel;
            mux_taken  = ex_taken;
            mux_stall  = 1'b0;
        end
    end

    // Next state, PC update and buffer capture
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        buf_push = 1'b0;

        if (ex_redirect || advance) begin
            pc_d = mux_next_pc;
        end

        case (state_q)
            FC_REQ: begin
                if (advance) begin
                    state_d  = FC_WAIT;
                    req_pc_d = pc_q;
                end
            end
            FC_WAIT: begin
                if (ex_redirect) begin
                    // Response (now or later) belongs to the old path.
                    state_d = imem_rsp_valid ? FC_REQ : FC_DRAIN;
                end else if (imem_rsp_valid) begin
                    state_d  = FC_REQ;
                    buf_push = 1'b1;
                end
            end
            FC_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = FC_REQ;
                end
            end
            default: begin
                state_d = FC_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FC_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

`ifdef FETCH_CTRL_MISALIGN_EN
    logic fault_q, fault_d;

    always_comb begin
        fault_d = fault_q;
        if (ex_redirect && is_misaligned(mux_next_pc)) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault_halt  = fault_q;
    assign fetch_fault = fault_q;
`else
    assign fault_halt = 1'b0;
`endif

    fetch_buf u_buf (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (ex_redirect),
        .push_i         (buf_push),
        .push_pc_i      (req_pc_q),
        .push_inst_i    (imem_rsp_data),
        .valid_o        (if_valid),
        .pc_o           (if_pc),
        .inst_o         (if_inst),
        .ready_i        (if_ready),
        .full_blocked_o (buf_blocked)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Scoreboard bench for fetch_ctrl. Each scenario pushes the request addresses
// and decode-side PCs it expects; a monitor pops and compares them on every
// memory accept and every decode handshake. The memory model returns ~addr as
// the instruction word with a programmable latency, and a small pc_mux model
// closes the PC loop. Build with FETCH_CTRL_MISALIGN_EN to add the fault case.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [31:0]             mux_pc, mux_rs1, mux_imm;
    logic [SEL_PC_WIDTH-1:0] mux_pc_sel;
    logic                    mux_taken, mux_stall;
    logic [31:0]             mux_next_pc;
    logic                    imem_req_valid;
    logic [31:0]             imem_req_addr;
    logic                    imem_req_ready;
    logic                    imem_rsp_valid;
    logic [31:0]             imem_rsp_data;
    logic                    if_valid;
    logic [31:0]             if_pc, if_inst;
    logic                    if_ready;
    logic                    ex_redirect;
    logic [SEL_PC_WIDTH-1:0] ex_pc_sel;
    logic                    ex_taken;
    logic [31:0]             ex_pc, ex_rs1, ex_imm;
    logic                    hazard_stall;
`ifdef FETCH_CTRL_MISALIGN_EN
    logic                    fetch_fault;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_if_q[$];

    int granted  = 0;
    int accepted = 0;
    int mem_lat  = 1;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .mux_pc         (mux_pc),
        .mux_rs1        (mux_rs1),
        .mux_imm        (mux_imm),
        .mux_pc_sel     (mux_pc_sel),
        .mux_taken      (mux_taken),
        .mux_stall      (mux_stall),
        .mux_next_pc    (mux_next_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_ready       (if_ready),
        .ex_redirect    (ex_redirect),
        .ex_pc_sel      (ex_pc_sel),
        .ex_taken       (ex_taken),
        .ex_pc          (ex_pc),
        .ex_rs1         (ex_rs1),
        .ex_imm         (ex_imm),
`ifdef FETCH_CTRL_MISALIGN_EN
        .fetch_fault    (fetch_fault),
`endif
        .hazard_stall   (hazard_stall)
    );

    // pc_mux model
    always_comb begin
        mux_next_pc = mux_pc + 32'd4;
        if (mux_stall)
            mux_next_pc = mux_pc;
        else if (mux_pc_sel == SEL_PC_JAL && mux_taken)
            mux_next_pc = mux_pc + mux_imm;
        else if (mux_pc_sel == SEL_PC_JALR && mux_taken)
            mux_next_pc = mux_rs1 + mux_imm;
    end

    // Memory accepts while the scenario still has grants left.
    assign imem_req_ready = (granted > accepted);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Memory model: one outstanding request, response mem_lat cycles after accept.
    initial begin
        logic        acc_n, rst_seen;
        logic [31:0] addr_n, pend;
        int          cnt;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        cnt  = 0;
        pend = 32'd0;
        forever begin
            @(negedge clk);
            rst_seen = rst;
            acc_n    = !rst && imem_req_valid && imem_req_ready;
            addr_n   = imem_req_addr;
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (rst_seen) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = ~pend;
                    end
                end
                if (acc_n) begin
                    accepted++;
                    pend = addr_n;
                    cnt  = mem_lat - 1;
                    if (cnt == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = ~pend;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: requests and decode handshakes.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && imem_req_valid && imem_req_ready) begin
                e = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hFFFF_FFFF;
                $display("req  addr=%08h", imem_req_addr);
                check_val("req_addr", imem_req_addr, e);
            end
            if (!rst && if_valid && if_ready) begin
                e = (exp_if_q.size() != 0) ? exp_if_q.pop_front() : 32'hFFFF_FFFF;
                $display("if   pc=%08h inst=%08h", if_pc, if_inst);
                check_val("if_pc", if_pc, e);
                check_val("if_inst", if_inst, ~e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst          = 1'b1;
        ex_redirect  = 1'b0;
        ex_pc_sel    = SEL_PC_ADD4;
        ex_taken     = 1'b0;
        ex_pc        = 32'd0;
        ex_rs1       = 32'd0;
        ex_imm       = 32'd0;
        hazard_stall = 1'b0;
        if_ready     = 1'b1;
        granted      = accepted;
        tick(2);
        @(negedge clk);
        check_val("rst_if_valid", 32'(if_valid), 32'd0);
        check_val("rst_if_pc", if_pc, 32'd0);
        check_val("rst_if_inst", if_inst, 32'd0);
        check_val("rst_pc", imem_req_addr, 32'h0000_0000);
`ifdef FETCH_CTRL_MISALIGN_EN
        check_val("rst_fault", 32'(fetch_fault), 32'd0);
`endif
        exp_addr_q.delete();
        exp_if_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive_redirect(input logic [SEL_PC_WIDTH-1:0] sel, input logic tk,
                                  input logic [31:0] pc, input logic [31:0] rs1,
                                  input logic [31:0] imm);
        ex_redirect = 1'b1;
        ex_pc_sel   = sel;
        ex_taken    = tk;
        ex_pc       = pc;
        ex_rs1      = rs1;
        ex_imm      = imm;
    endtask

    // Returns at the negedge just before an accept edge.
    task automatic wait_accept();
        logic found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                found = 1'b1;
                break;
            end
        end
        check_val("accept_seen", 32'(found), 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_addr_q.size() == 0 && exp_if_q.size() == 0) break;
            tick(1);
        end
        tick(3);
        check_val("addr_q_left", 32'(exp_addr_q.size()), 32'd0);
        check_val("if_q_left", 32'(exp_if_q.size()), 32'd0);
    endtask

    initial begin
        int  first_idx;
        rst = 1'b1;

        // Sequential fetch 0,4,8,C with 1-cycle memory
        mem_lat = 1;
        do_reset();
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_if_q   = '{32'h0, 32'h4, 32'h8, 32'hC};
        granted += 4;
        first_idx = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check_val("seq_sel", 32'(mux_pc_sel), 32'(SEL_PC_ADD4));
                check_val("seq_taken", 32'(mux_taken), 32'd0);
                check_val("seq_stall", 32'(mux_stall), 32'd0);
            end
            if (if_valid) begin
                first_idx = i;
                break;
            end
        end
        check_val("first_latency", 32'(first_idx), 32'd2);
        wait_drain();

        // JAL redirect while request outstanding: stale response drained
        mem_lat = 3;
        do_reset();
        exp_addr_q = '{32'h0, 32'h10, 32'h14};
        exp_if_q   = '{32'h10, 32'h14};
        granted += 3;
        wait_accept();
        @(posedge clk); #1;
        drive_redirect(SEL_PC_JAL, 1'b1, 32'h8, 32'h0, 32'h8);
        @(negedge clk);
        check_val("jal_mux_pc", mux_pc, 32'h8);
        check_val("jal_mux_imm", mux_imm, 32'h8);
        check_val("jal_mux_taken", 32'(mux_taken), 32'd1);
        check_val("jal_mux_stall", 32'(mux_stall), 32'd0);
        @(posedge clk); #1;
        ex_redirect = 1'b0;
        @(negedge clk);
        check_val("drain_req_valid", 32'(imem_req_valid), 32'd0);
        check_val("jal_pc", imem_req_addr, 32'h10);
        wait_drain();

        // JALR with response in the same cycle, then not-taken branch in REQ
        mem_lat = 1;
        do_reset();
        exp_addr_q = '{32'h0, 32'h10};
        exp_if_q   = '{32'h10};
        granted += 2;
        wait_accept();
        @(posedge clk); #1;
        drive_redirect(SEL_PC_JALR, 1'b1, 32'h40, 32'h8, 32'h8);
        @(negedge clk);
        check_val("jalr_sel", 32'(mux_pc_sel), 32'(SEL_PC_JALR));
        check_val("jalr_rs1", mux_rs1, 32'h8);
        @(posedge clk); #1;
        ex_redirect = 1'b0;
        @(negedge clk);
        check_val("jalr_pc", imem_req_addr, 32'h10);
        wait_drain();
        exp_addr_q.push_back(32'h24);
        exp_if_q.push_back(32'h24);
        drive_redirect(SEL_PC_JAL, 1'b0, 32'h20, 32'h0, 32'h100);
        @(negedge clk);
        check_val("br_mux_pc", mux_pc, 32'h20);
        check_val("br_taken", 32'(mux_taken), 32'd0);
        @(posedge clk); #1;
        ex_redirect = 1'b0;
        granted += 1;
        @(negedge clk);
        check_val("br_pc", imem_req_addr, 32'h24);
        wait_drain();

        // Hazard stall for 4 cycles at address 8
        mem_lat = 1;
        do_reset();
        exp_addr_q = '{32'h0, 32'h4, 32'h8};
        exp_if_q   = '{32'h0, 32'h4, 32'h8};
        granted += 2;
        tick(6);
        hazard_stall = 1'b1;
        granted += 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("hz_stall", 32'(mux_stall), 32'd1);
            check_val("hz_req_valid", 32'(imem_req_valid), 32'd0);
            check_val("hz_addr", imem_req_addr, 32'h8);
            @(posedge clk); #1;
        end
        hazard_stall = 1'b0;
        wait_drain();

        // Decode back-pressure with a full buffer
        mem_lat = 1;
        do_reset();
        if_ready = 1'b0;
        exp_addr_q = '{32'h0, 32'h4, 32'h8};
        exp_if_q   = '{32'h0, 32'h4, 32'h8};
        granted += 3;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (if_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            check_val("bp_if_valid", 32'(seen), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_req_valid", 32'(imem_req_valid), 32'd0);
            check_val("bp_if_pc", if_pc, 32'h0);
            check_val("bp_if_inst", if_inst, 32'hFFFF_FFFF);
        end
        @(posedge clk); #1;
        if_ready = 1'b1;
        wait_drain();

`ifdef FETCH_CTRL_MISALIGN_EN
        // Misaligned JALR target: sticky fault, no further requests
        mem_lat = 1;
        do_reset();
        tick(2);
        @(negedge clk);
        check_val("fault_before", 32'(fetch_fault), 32'd0);
        @(posedge clk); #1;
        drive_redirect(SEL_PC_JALR, 1'b1, 32'h0, 32'h5, 32'h0);
        @(posedge clk); #1;
        ex_redirect = 1'b0;
        granted += 4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("fault_set", 32'(fetch_fault), 32'd1);
            check_val("fault_req_valid", 32'(imem_req_valid), 32'd0);
            check_val("fault_pc", imem_req_addr, 32'h5);
            @(posedge clk); #1;
        end
        do_reset();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the architectural fetch PC register and drives the pc_mux select/taken/stall inputs every cycle.
- Issues one outstanding instruction-memory request at a time and buffers one response for decode.
- Applies execute-stage redirects (JAL/JALR/branch) and hazard stalls.
- Sits between the execute/hazard logic and pc_mux / instruction memory / decode.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- mux_pc, output, 32, pc operand to pc_mux.
- mux_rs1, output, 32, rs1 operand to pc_mux.
- mux_imm, output, 32, imm operand to pc_mux.
- mux_pc_sel, output, `SEL_PC_WIDTH, pc_mux select.
- mux_taken, output, 1, pc_mux taken.
- mux_stall, output, 1, pc_mux stall.
- mux_next_pc, input, 32, pc_mux result.
- imem_req_valid, output, 1, fetch request valid.
- imem_req_addr, output, 32, fetch address.
- imem_req_ready, input, 1, memory accepts request.
- imem_rsp_valid, input, 1, response valid; at least 1 cycle after accept, exactly one per accepted request.
- imem_rsp_data, input, 32, instruction word.
- if_valid, output, 1, instruction available to decode.
- if_pc, output, 32, PC of if_inst.
- if_inst, output, 32, instruction word.
- if_ready, input, 1, decode accepts.
- ex_redirect, input, 1, execute requests PC change.
- ex_pc_sel, input, `SEL_PC_WIDTH, redirect kind (`SEL_PC_JAL or `SEL_PC_JALR).
- ex_taken, input, 1, redirect condition (branch outcome; 1 for jumps).
- ex_pc, input, 32, PC of redirecting instruction.
- ex_rs1, input, 32, JALR base.
- ex_imm, input, 32, offset.
- hazard_stall, input, 1, freeze fetch.

Behaviour:
- Reset (rst=1 at edge): state=REQ, pc_q=RESET_PC, buffer empty, if_valid=0, if_pc=0, if_inst=0, fault=0.
- Reset mid-operation: any in-flight response is ignored, because the state leaves WAIT/DRAIN.
- States:
  - REQ: imem_req_valid=1, addr=pc_q.
  - WAIT: request outstanding.
  - DRAIN: outstanding response is to be discarded.
- Mux drive, combinational:
  - If ex_redirect: mux_pc=ex_pc, rs1=ex_rs1, imm=ex_imm, sel=ex_pc_sel, taken=ex_taken, stall=0.
  - Else: mux_pc=pc_q, sel=`SEL_PC_ADD4, taken=0, stall=~advance.
  - advance = REQ & imem_req_ready & ~hazard_stall & ~buffer_full_blocked.
- pc_q <= mux_next_pc when ex_redirect or advance; otherwise it holds.
- Priority: redirect > hazard_stall > normal advance.
- REQ→WAIT on advance. In REQ, imem_req_valid is deasserted while hazard_stall=1 or buffer full with if_ready=0.
- WAIT + rsp_valid + no redirect: capture {pc,inst} into buffer, if_valid=1, go to REQ.
- WAIT + redirect with no rsp same cycle: go to DRAIN.
- WAIT + redirect with rsp same cycle: discard rsp, go to REQ.
- DRAIN + rsp_valid: discard, go to REQ. A further redirect in DRAIN only updates pc_q.
- Redirect always clears the buffer (if_valid←0). The redirected instruction's own fetch-after is the new pc_q.
- Buffer: 1 entry. It pops when if_valid & if_ready. Pop and capture in the same cycle is allowed. if_pc/if_inst stay stable while if_valid & ~if_ready.
- Fetch-to-if_valid latency: 2 cycles minimum (req accept, rsp next cycle, registered output).
- PC arithmetic: 32-bit wrap (32'hFFFF_FFFC + 4 = 0), performed by pc_mux.

Optional Feature:
- Macro FETCH_CTRL_MISALIGN_EN.
- Defined: adds output fetch_fault (1 bit, reset 0). If a redirect produces mux_next_pc[1:0]!=0, pc_q still loads, fetch_fault is set (sticky until rst), and state holds in REQ with imem_req_valid=0.
- Undefined: no port; misaligned targets are fetched as-is.

Decomposition:
- Package/header param_fetch_ctrl.vh: state encodings (FC_REQ, FC_WAIT, FC_DRAIN, width 2).
- Reuse the existing SEL_PC_* defines from the pc_mux header.
- Sub-module fetch_buf: 1-entry pc/inst skid register with valid/ready.
- pc_mux is instantiated in the parent, not inside fetch_ctrl.

Test Plan:
- Reset, memory ready always, 1-cycle rsp, if_ready=1: imem_req_addr sequence 0,4,8,C; if_pc matches with 2-cycle lag; mux_pc_sel=ADD4.
- JAL redirect ex_pc=8, ex_imm=8, taken=1 while request outstanding: pc_q=0x10; stale rsp discarded via DRAIN; next if_pc=0x10.
- JALR ex_rs1=8, imm=8: next fetch addr 0x10. Branch with ex_taken=0 at ex_pc=0x20: next fetch 0x24.
- hazard_stall=1 for 4 cycles: mux_stall=1, pc_q and imem_req_addr constant, no new requests; resume at the same address.
- if_ready=0 with buffer full: no new request issued, if_inst stable; after if_ready=1, fetch resumes.
- FETCH_CTRL_MISALIGN_EN: JALR rs1=5, imm=0: fetch_fault=1, imem_req_valid stays 0 until rst.
